fmadd_post_norm_pipe: RTL and testbench
=======================================

FMADD_POST_NORM_PIPE -- requirements
Module: fmadd_post_norm_pipe

Interface
REQ-001 Parameter MAN, default 22: stored-mantissa MSB index; input product/sum width is 2*MAN+4, output mantissa width is MAN+2.
REQ-002 Parameter EXP, default 7: exponent MSB index; exponent width is EXP+2.
REQ-003 Parameter LZD, default 4: leading-zero-count MSB index; LZD+1 bits SHALL hold the value MAN+2.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  block accepts the beat this cycle.
REQ-008 in_man  input  2*MAN+4  unnormalised mantissa.
REQ-009 in_exp  input  EXP+2  unnormalised exponent, unsigned.
REQ-010 in_carry, in_eff_sub, in_eff_add  input  1 each  adder carry-out and effective-operation selects.
REQ-011 in_guard, in_round, in_sticky  input  1 each  rounding bits from alignment.
REQ-012 out_valid  output  1; out_ready  input  1  output handshake.
REQ-013 out_man  output  MAN+2; out_exp  output  EXP+2; out_guard, out_round, out_sticky  output  1 each.
REQ-014 out_zero, out_denorm  output  1 each  result-zero and exponent-limited-shift flags.

Function
REQ-015 Transfer SHALL occur on a valid&&ready cycle; the pipeline SHALL have two register stages (S1, S2), latency 2 cycles, throughput 1 beat/cycle when out_ready=1.
REQ-016 S1 SHALL register the inputs, LZC and shift amount; S2 SHALL register the shifted mantissa, exponent and flags; out_* SHALL be driven from S2.
REQ-017 A stage SHALL advance when it is empty or the downstream stage advances; in_ready = !S1_valid || S1 advances (combinational from out_ready).
REQ-018 While out_valid=1 and out_ready=0, all out_* SHALL remain stable.
REQ-019 in_eff_sub SHALL take priority over in_eff_add when both are 1.
REQ-020 Sub lane: LZC = leading zeros of in_man[2*MAN+3:MAN+2], with LZC=MAN+2 when that field is all zero.
REQ-021 Sub lane: if in_exp > LZC, shamt=LZC and out_denorm=0; otherwise shamt = (in_exp==0 ? 0 : in_exp-1) and out_denorm=1.
REQ-022 Sub lane: interim mantissa = in_man << shamt; out_exp = in_exp - shamt.
REQ-023 Add lane: if in_carry=1, interim = {1, in_man[2*MAN+3:1]} and the dropped in_man[0] SHALL be ORed into sticky; otherwise interim = in_man.
REQ-024 Add lane: out_exp = in_exp + in_carry, truncated to EXP+2 bits; out_denorm=0.
REQ-025 Neither select: interim = 0; out_exp = in_exp + in_carry; out_denorm=0.
REQ-026 out_man = interim[2*MAN+3:MAN+2]; out_guard = interim[MAN+1]; out_round = interim[MAN].
REQ-027 out_sticky = |interim[MAN-1:0] | in_guard | in_round | in_sticky | (add-lane dropped bit).
REQ-028 out_zero = 1 when out_man, out_guard, out_round and out_sticky are all 0.
REQ-029 Beats SHALL leave in acceptance order; no beat SHALL be dropped or duplicated.

Reset
REQ-030 While rst=1: S1_valid=S2_valid=0, out_valid=0, all out_* data and flags=0, in_ready=0.
REQ-031 The first cycle after rst deasserts SHALL have in_ready=1; beats in flight at reset SHALL be discarded and never appear on the output.

Verification (MAN=22, EXP=7)
REQ-032 Add with carry: eff_add=1, carry=1, exp=0x080, man=48'h800000000001, g=r=s=0 -> 2 cycles later out_exp=0x081, out_man=0xC00000, guard=0, round=0, sticky=1.
REQ-033 Sub normal: eff_sub=1, exp=0x080, man=48'h000040000000 -> LZC=17, out_exp=0x06F, out_man=0x800000, out_denorm=0.
REQ-034 Sub exp-limited: eff_sub=1, exp=0x010, same man -> shamt=15, out_exp=0x001, out_man=0x200000, out_denorm=1.
REQ-035 Sub zero: eff_sub=1, exp=0x080, man=0 -> shamt=24, out_exp=0x068, out_man=0, out_zero=1.
REQ-036 Backpressure: 3 back-to-back beats with out_ready=0 -> in_ready=0 after 2 are held; out_* stable; on out_ready=1 all 3 emerge in order, one per cycle.
REQ-037 Reset mid-operation: rst=1 for 1 cycle with both stages valid -> next cycle out_valid=0; the following cycle in_ready=1; no pre-reset beat ever appears on the output.

Source files
------------

// File: rtl/fmadd_post_norm_pipe.sv
// fmadd_post_norm_pipe: two-stage post-normalisation of an FMA adder result (LZC, shift, exponent fix-up, sticky collection)
module fmadd_post_norm_pipe #(
    parameter int MAN = 22,
    parameter int EXP = 7,
    parameter int LZD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*MAN+3:0]   in_man,
    input  logic [EXP+1:0]     in_exp,
    input  logic               in_carry,
    input  logic               in_eff_sub,
    input  logic               in_eff_add,
    input  logic               in_guard,
    input  logic               in_round,
    input  logic               in_sticky,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAN+1:0]     out_man,
    output logic [EXP+1:0]     out_exp,
    output logic               out_guard,
    output logic               out_round,
    output logic               out_sticky,
    output logic               out_zero,
    output logic               out_denorm
);
    localparam int W  = 2*MAN+4;
    localparam int EW = EXP+2;
    localparam int LW = LZD+1;

    logic           s1_valid, s1_sub, s1_add, s1_carry, s1_grs, s1_denorm;
    logic [W-1:0]   s1_man;
    logic [EW-1:0]  s1_exp;
    logic [LW-1:0]  s1_lzc, s1_shamt;
    logic           s1_adv, s2_adv;

    logic [LW-1:0]  lzc, shamt;
    logic [EW-1:0]  exp_m1;
    logic           lim;

    logic [W-1:0]   sh, add_i, interim;
    logic           drop, n_sticky, n_zero;
    logic [EW-1:0]  n_exp;

    assign s2_adv    = !out_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = !rst && s1_adv;

    // leading zeros of the upper mantissa field; an all-zero field counts as full width
    always_comb begin
        lzc = LW'(MAN + 2);
        for (int i = 0; i < MAN + 2; i++)
            if (in_man[MAN + 2 + i]) lzc = LW'(MAN + 1 - i);
    end

    // shift is capped so the exponent never drops below one (zero exponent stays unshifted)
    always_comb begin
        exp_m1 = in_exp - EW'(1);
        lim    = !(in_exp > EW'(lzc));
        shamt  = !lim ? lzc : (in_exp == '0 ? '0 : exp_m1[LW-1:0]);
    end

    // stage 1: capture operands, lane select (sub wins), LZC and shift amount
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sub    <= 1'b0;
            s1_add    <= 1'b0;
            s1_carry  <= 1'b0;
            s1_grs    <= 1'b0;
            s1_denorm <= 1'b0;
            s1_man    <= '0;
            s1_exp    <= '0;
            s1_lzc    <= '0;
            s1_shamt  <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sub    <= in_eff_sub;
                s1_add    <= !in_eff_sub && in_eff_add;
                s1_carry  <= in_carry;
                s1_grs    <= in_guard | in_round | in_sticky;
                s1_denorm <= in_eff_sub && lim;
                s1_man    <= in_man;
                s1_exp    <= in_exp;
                s1_lzc    <= lzc;
                s1_shamt  <= shamt;
            end
        end
    end

    // lane datapath: normalising left shift for sub, carry right-shift for add, zero otherwise
    always_comb begin
        sh       = s1_man << s1_shamt;
        add_i    = s1_carry ? {1'b1, s1_man[W-1:1]} : s1_man;
        interim  = s1_sub ? sh : (s1_add ? add_i : '0);
        drop     = s1_add & s1_carry & s1_man[0];
        n_exp    = s1_sub ? s1_exp - EW'(s1_shamt) : s1_exp + EW'(s1_carry);
        n_sticky = (|interim[MAN-1:0]) | s1_grs | drop;
        n_zero   = !((|interim[W-1:MAN]) | n_sticky);
    end

    // stage 2: output registers, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_man    <= '0;
            out_exp    <= '0;
            out_guard  <= 1'b0;
            out_round  <= 1'b0;
            out_sticky <= 1'b0;
            out_zero   <= 1'b0;
            out_denorm <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_man    <= interim[W-1:MAN+2];
                out_exp    <= n_exp;
                out_guard  <= interim[MAN+1];
                out_round  <= interim[MAN];
                out_sticky <= n_sticky;
                out_zero   <= n_zero;
                out_denorm <= s1_denorm;
            end
        end
    end
endmodule

// File: tb/tb_fmadd_post_norm_pipe.sv
// tb_fmadd_post_norm_pipe: directed vectors with a queue scoreboard and decoupled output monitor
module tb_fmadd_post_norm_pipe;
    typedef struct packed {
        logic [23:0] man;
        logic [8:0]  exp;
        logic        g, r, s, z, d;
    } res_t;

    typedef struct packed {
        logic        sub, add, carry, g, r, s;
        logic [8:0]  exp;
        logic [47:0] man;
        res_t        e;
    } vec_t;

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready;
    logic [47:0] in_man = '0;
    logic [8:0]  in_exp = '0;
    logic        in_carry = 0, in_eff_sub = 0, in_eff_add = 0;
    logic        in_guard = 0, in_round = 0, in_sticky = 0;
    logic        out_valid, out_ready = 1;
    logic [23:0] out_man;
    logic [8:0]  out_exp;
    logic        out_guard, out_round, out_sticky, out_zero, out_denorm;

    int   n_cmp = 0, n_err = 0;
    res_t sb[$];
    vec_t vecs[13];
    res_t held;
    logic hold_v = 0;

    fmadd_post_norm_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_man(in_man), .in_exp(in_exp),
        .in_carry(in_carry), .in_eff_sub(in_eff_sub), .in_eff_add(in_eff_add),
        .in_guard(in_guard), .in_round(in_round), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_man(out_man), .out_exp(out_exp),
        .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky),
        .out_zero(out_zero), .out_denorm(out_denorm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        in_valid = 1; in_man = v.man; in_exp = v.exp; in_carry = v.carry;
        in_eff_sub = v.sub; in_eff_add = v.add;
        in_guard = v.g; in_round = v.r; in_sticky = v.s;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 100) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 0;
        if (n <= 100) sb.push_back(v.e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 0);
    endtask

    // monitor: pops on every output transfer and checks stability while stalled
    always @(negedge clk) begin
        res_t cur, e;
        cur = '{out_man, out_exp, out_guard, out_round, out_sticky, out_zero, out_denorm};
        if (rst) hold_v = 0;
        else if (out_valid) begin
            if (hold_v) chk("stable", cur, held);
            if (out_ready) begin
                hold_v = 0;
                if (sb.size() == 0) chk("unexpected_output", cur, 0);
                else begin
                    e = sb.pop_front();
                    chk("out_man", cur.man, e.man);
                    chk("out_exp", cur.exp, e.exp);
                    chk("out_guard", cur.g, e.g);
                    chk("out_round", cur.r, e.r);
                    chk("out_sticky", cur.s, e.s);
                    chk("out_zero", cur.z, e.z);
                    chk("out_denorm", cur.d, e.d);
                end
            end else begin
                held = cur;
                hold_v = 1;
            end
        end else hold_v = 0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            sub add cy g r s  exp     man                    man        exp    g r s z d
        vecs[0]  = '{0,1,1,0,0,0, 9'h080, 48'h800000000001, '{24'hC00000, 9'h081, 0,0,1,0,0}};
        vecs[1]  = '{1,0,0,0,0,0, 9'h080, 48'h000040000000, '{24'h800000, 9'h06F, 0,0,0,0,0}};
        vecs[2]  = '{1,0,0,0,0,0, 9'h010, 48'h000040000000, '{24'h200000, 9'h001, 0,0,0,0,1}};
        vecs[3]  = '{1,0,0,0,0,0, 9'h080, 48'h000000000000, '{24'h000000, 9'h068, 0,0,0,1,0}};
        vecs[4]  = '{0,1,0,0,0,0, 9'h0FE, 48'h123456C00001, '{24'h123456, 9'h0FE, 1,1,1,0,0}};
        vecs[5]  = '{0,0,1,0,0,0, 9'h1FF, 48'hFFFFFFFFFFFF, '{24'h000000, 9'h000, 0,0,0,1,0}};
        vecs[6]  = '{1,1,1,1,0,0, 9'h005, 48'h000000800000, '{24'h000008, 9'h001, 0,0,1,0,1}};
        vecs[7]  = '{1,0,0,0,0,0, 9'h000, 48'h000000000003, '{24'h000000, 9'h000, 0,0,1,0,1}};
        vecs[8]  = '{1,0,0,0,0,0, 9'h012, 48'h000040000000, '{24'h800000, 9'h001, 0,0,0,0,0}};
        vecs[9]  = '{1,0,0,0,0,0, 9'h011, 48'h000040000000, '{24'h400000, 9'h001, 0,0,0,0,1}};
        vecs[10] = '{0,1,0,0,1,0, 9'h042, 48'h000000000000, '{24'h000000, 9'h042, 0,0,1,0,0}};
        vecs[11] = '{1,0,0,0,0,0, 9'h080, 48'h000000C00001, '{24'hC00001, 9'h068, 0,0,0,0,0}};
        vecs[12] = '{1,0,0,0,0,0, 9'h080, 48'h000001E00001, '{24'hF00000, 9'h069, 1,0,0,0,0}};

        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_man", out_man, 0);
            chk("rst_out_exp", out_exp, 0);
            chk("rst_out_flags", {out_guard, out_round, out_sticky, out_zero, out_denorm}, 0);
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        foreach (vecs[i]) send(vecs[i]);
        drain();

        out_ready = 0;
        send(vecs[0]);
        send(vecs[1]);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        fork
            send(vecs[2]);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_stream_valid", out_valid, 1);
                end
            end
        join
        drain();

        out_ready = 0;
        send(vecs[4]);
        send(vecs[5]);
        rst = 1;
        sb.delete();
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1;
        send(vecs[3]);
        drain();
        repeat (5) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
